staged_data_memory: RTL

// - MEM-stage data memory for the MIPS-lite pipeline: byte-addressed, big-endian, image preloaded from a hex file.
// - Successor to the single-cycle word memory. Adds byte/half/word access with sign or zero extension,

---
 rtl/mips_pkg.sv | 46 ++++
 rtl/staged_data_memory_load_align_ext.sv | 25 ++
 rtl/staged_data_memory.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS-lite types and constants.
// Includes the data memory boot image used for preload and reset restore.
package mips_pkg;

  localparam int DATA           = 32;
  localparam int ADDRESSWIDTH   = 32;
  localparam int MEMWIDTH       = 8;
  localparam int MEMDEPTH       = 256;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  // Contents of data.mem, one big-endian word per entry; the rest is zero.
  function automatic logic [DATA-1:0] image_word(input int unsigned w);
    logic [DATA-1:0] v;
    case (w)
      0:       v = 32'h8899_AABB;
      1:       v = 32'h0102_0304;
      2:       v = 32'hCAFE_F00D;
      3:       v = 32'h7F80_FF00;
      4:       v = 32'h1234_5678;
      5:       v = 32'hA5A5_5A5A;
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [MEMWIDTH-1:0] image_byte(input int unsigned a);
    logic [DATA-1:0] w;
    logic [1:0]      lane;
    w    = image_word(a / 4);
    lane = 2'(a % 4);
    return w[8*(3-lane) +: 8];
  endfunction

endpackage

// File: rtl/staged_data_memory_load_align_ext.sv
// Right-aligns a big-endian fetch and sign/zero extends it.
// Combinational; also intended for a future cache fill path.
module load_align_ext
  import mips_pkg::*;
(
  input  logic [BYTES_PER_WORD*MEMWIDTH-1:0] bytes,
  input  logic [1:0]                         size,
  input  logic                               is_unsigned,
  output logic [DATA-1:0]                    data
);

  logic sign;

  always_comb begin
    data = '0;
    sign = ~is_unsigned & bytes[31];
    unique case (1'b1)
      (size == SZ_BYTE): data = {{24{sign}}, bytes[31:24]};
      (size == SZ_HALF): data = {{16{sign}}, bytes[31:16]};
      (size == SZ_WORD): data = bytes;
      default:           data = '0;
    endcase
  end

endmodule

// File: rtl/staged_data_memory.sv
// MEM-stage data memory: big-endian byte array, sized accesses,
// alignment/range faults, fixed multi-cycle latency behind valid/ready.
module staged_data_memory
  import mips_pkg::*;
#(
  parameter int DEPTH        = MEMDEPTH,
  parameter int LATENCY      = 2,
  parameter bit ERR_ON_RANGE = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [ADDRESSWIDTH-1:0] req_addr,
  input  logic [DATA-1:0]         req_wdata,
  output logic                    resp_valid,
  output logic [DATA-1:0]         resp_rdata,
  output logic                    resp_err,
  output logic                    busy
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [MEMWIDTH-1:0] mem [DEPTH];

  dmem_state_t state;
  logic [3:0]  cnt;

  logic                    r_write;
  logic [1:0]              r_size;
  logic                    r_unsigned;
  logic [ADDRESSWIDTH-1:0] r_addr;
  logic [DATA-1:0]         r_wdata;

  logic                    idle;
  logic                    a_write;
  logic [1:0]              a_size;
  logic                    a_unsigned;
  logic [ADDRESSWIDTH-1:0] a_addr;
  logic [DATA-1:0]         a_wdata;

  logic [AW-1:0] i0, i1, i2, i3;
  logic [BYTES_PER_WORD*MEMWIDTH-1:0] fetched;
  logic [DATA-1:0] load_data;
  logic [2:0]      nbytes;
  logic            range_bad;
  logic            fault;
  logic            enter_resp;
  logic            commit;

  // With LATENCY==1 the access happens on the accept edge itself,
  // so the live request is used instead of the captured one.
  assign idle       = (state == IDLE);
  assign a_write    = idle ? req_write    : r_write;
  assign a_size     = idle ? req_size     : r_size;
  assign a_unsigned = idle ? req_unsigned : r_unsigned;
  assign a_addr     = idle ? req_addr     : r_addr;
  assign a_wdata    = idle ? req_wdata    : r_wdata;

  assign i0 = a_addr[AW-1:0];
  assign i1 = i0 + AW'(1);
  assign i2 = i0 + AW'(2);
  assign i3 = i0 + AW'(3);

  assign fetched = {mem[i0], mem[i1], mem[i2], mem[i3]};

  always_comb begin
    nbytes = 3'd0;
    unique case (1'b1)
      (a_size == SZ_BYTE): nbytes = 3'd1;
      (a_size == SZ_HALF): nbytes = 3'd2;
      (a_size == SZ_WORD): nbytes = 3'd4;
      default:             nbytes = 3'd0;
    endcase
  end

  assign range_bad =
    ({1'b0, a_addr} + 33'(nbytes)) > 33'(DEPTH);

  assign fault =
    (a_size == 2'b11) |
    ((a_size == SZ_HALF) & a_addr[0]) |
    ((a_size == SZ_WORD) & (|a_addr[1:0])) |
    (ERR_ON_RANGE & range_bad);

  assign enter_resp =
    ((state == WAIT) && (cnt == 4'd1)) ||
    (idle && req_valid && (LATENCY == 1));

  assign commit = enter_resp & ~fault & a_write;

  load_align_ext u_align (
    .bytes       (fetched),
    .size        (a_size),
    .is_unsigned (a_unsigned),
    .data        (load_data)
  );

  // Reset restores the whole boot image in a single cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= image_byte(i);
      end
    end else if (commit) begin
      unique case (1'b1)
        (a_size == SZ_BYTE): begin
          mem[i0] <= a_wdata[7:0];
        end
        (a_size == SZ_HALF): begin
          mem[i0] <= a_wdata[15:8];
          mem[i1] <= a_wdata[7:0];
        end
        default: begin
          mem[i0] <= a_wdata[31:24];
          mem[i1] <= a_wdata[23:16];
          mem[i2] <= a_wdata[15:8];
          mem[i3] <= a_wdata[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      r_write    <= 1'b0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      resp_valid <= enter_resp;
      if (enter_resp) begin
        resp_err   <= fault;
        resp_rdata <= (fault | a_write) ? '0 : load_data;
      end
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            r_write    <= req_write;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            cnt        <= CNT_INIT;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
